gate_parity_stream: RTL
=======================

# gate_parity_stream

Streaming parity engine that generalises the 3-input XNOR gate to a WIDTH-bit word and accumulates the result across a multi-beat frame. It accepts words over a valid/ready handshake and reduces each word to one parity bit. It combines those bits over a frame terminated by `in_last` or by a beat limit, then presents one registered XOR (odd) or XNOR (even) result. It sits in the GATE library as the reusable, sequential successor to the single-word gate models.

## Interface
Parameters:
- `WIDTH`, 3: data word width, ≥1.
- `MAX_BEATS`, 8: maximum beats per frame, ≥1; forces frame end.
- `CNT_W`, $clog2(MAX_BEATS+1): beat counter width (derived, not overridden).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  WIDTH  data word.
- `in_last`  in  1  final beat of the frame.
- `in_mode`  in  1  0 = XOR (odd parity), 1 = XNOR (even parity); sampled on the first beat of each frame.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_parity`  out  1  frame result.
- `out_beats`  out  CNT_W  beats in the frame, 1..MAX_BEATS.
- `out_trunc`  out  1  frame ended by MAX_BEATS with no `in_last`.

## Operation
- A beat is accepted when `in_valid && in_ready`; a result is taken when `out_valid && out_ready`.
- States:
  - IDLE: no frame open.
  - ACCUM: frame open, at least one beat accepted.
  - HOLD: result presented.
- Word parity `w = ^in_data`.
- First beat (IDLE): `acc <= w`, `cnt <= 1`, latch `in_mode`.
- Later beats (ACCUM): `acc <= acc ^ w`, `cnt <= cnt + 1`.
- Frame ends on an accepted beat with `in_last`=1, or when `cnt` reaches MAX_BEATS.
  - `out_parity <= acc_next ^ mode_latched`.
  - `out_beats <= cnt_next`.
  - `out_trunc <= !in_last`.
  - Next state is HOLD.
- `in_last` and the MAX_BEATS limit in the same beat: `out_trunc`=0.
- MAX_BEATS=1: every beat is a frame.
- `in_mode` changes mid-frame are ignored.
- `in_ready` = (state != HOLD), driven combinationally from the state register.
- HOLD:
  - Outputs stay stable until the result is taken.
  - `in_valid` is ignored.
  - On the take, the next state is IDLE.
- `in_data` and `in_last` are don't-care while `in_valid`=0.

## Timing
- Reset values:
  - State: IDLE.
  - `in_ready`=1.
  - `out_valid`=0, `out_parity`=0, `out_beats`=0, `out_trunc`=0.
  - `acc`=0, `cnt`=0.
  - `out_err`=0 when configured.
- Reset mid-frame or in HOLD discards all state on the next edge.
- Latency: `out_valid` rises on the edge that accepts the final beat, so it is visible the following cycle.
- Throughput: one bubble per frame. The cycle after the result is taken, `in_ready` is already 1 (IDLE), so the back-to-back frame cost is N beats + 1 HOLD cycle minimum.
- `out_ready` may be held high permanently; HOLD then lasts exactly one cycle.

## Configuration
- `GATE_PARITY_STREAM_CHECK_EN` defined:
  - Adds input `in_exp` (1 bit), sampled with the frame's final beat.
  - Adds output `out_err` (1 bit) = (`out_parity` != `in_exp`), registered alongside `out_parity` and valid with `out_valid`.
- Not defined: neither port exists; behaviour is otherwise identical.

## Structure
- Shared package `gate_pkg`:
  - State enum `gps_state_t` {IDLE, ACCUM, HOLD}.
  - Mode constants `GATE_MODE_XOR`=0 and `GATE_MODE_XNOR`=1.
- Sub-module `gate_reduce`:
  - Parametrised combinational WIDTH-input XOR/XNOR reducer with a mode input.
  - Instantiated once for word parity; reusable as the generic N-input gate.

## Test plan
1. WIDTH=3, single beat `in_data`=3'b000, `in_last`=1, `in_mode`=1 -> next cycle `out_valid`=1, `out_parity`=1, `out_beats`=1, `out_trunc`=0.
2. Beats 3'b001, 3'b011, 3'b111 (last), `in_mode`=0, `out_ready`=1 -> `out_parity`=0, `out_beats`=3; HOLD lasts one cycle.
3. 8 beats of 3'b100 with no `in_last`, MAX_BEATS=8, `in_mode`=0 -> frame ends after beat 8 with `out_trunc`=1, `out_parity`=0, `out_beats`=8.
4. Result pending, `out_ready`=0 for 5 cycles with `in_valid`=1 -> `in_ready`=0 and all outputs unchanged throughout; after `out_ready`=1, the next frame accepts its beat from IDLE.
5. `rst`=1 after 2 beats of a frame -> all outputs at reset values next cycle; a subsequent 1-beat frame of 3'b001 with `in_mode`=0 gives `out_parity`=1, `out_beats`=1.
6. With `GATE_PARITY_STREAM_CHECK_EN` defined: frame 3'b011 (last), `in_mode`=0, `in_exp`=1 -> `out_parity`=0, `out_err`=1; repeat with `in_exp`=0 -> `out_err`=0.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared types and constants for the GATE library parity/reducer blocks.
package gate_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } gps_state_t;

    localparam logic GATE_MODE_XOR  = 1'b0;
    localparam logic GATE_MODE_XNOR = 1'b1;

endpackage

// File: rtl/gate_reduce.sv
// Combinational WIDTH-input XOR/XNOR reducer; the generic N-input gate model.
module gate_reduce #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] data,
    input  logic             mode,
    output logic             y
);

    // mode=1 inverts the odd-parity result, giving the XNOR gate.
    assign y = (^data) ^ mode;

endmodule

// File: rtl/gate_parity_stream.sv
// Streaming frame parity engine over a valid/ready handshake.
// Define GATE_PARITY_STREAM_CHECK_EN to add the in_exp / out_err checker ports.
module gate_parity_stream
    import gate_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int MAX_BEATS = 8,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_mode,
`ifdef GATE_PARITY_STREAM_CHECK_EN
    input  logic             in_exp,
    output logic             out_err,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_trunc
);

    gps_state_t       state;
    logic             acc;
    logic             mode_q;
    logic [CNT_W-1:0] cnt;

    logic             w;
    logic             first;
    logic             accept;
    logic             acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             mode_eff;
    logic             frame_end;
    logic             par_next;

    gate_reduce #(.WIDTH(WIDTH)) u_word_parity (
        .data (in_data),
        .mode (GATE_MODE_XOR),
        .y    (w)
    );

    assign in_ready = (state != HOLD);

    // The first beat restarts the accumulator and supplies the frame's mode directly.
    always_comb begin
        first     = (state == IDLE);
        accept    = in_valid && in_ready;
        acc_next  = first ? w : (acc ^ w);
        cnt_next  = first ? CNT_W'(1) : (cnt + CNT_W'(1));
        mode_eff  = first ? in_mode : mode_q;
        frame_end = in_last || (cnt_next == CNT_W'(MAX_BEATS));
        par_next  = acc_next ^ mode_eff;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= 1'b0;
            cnt        <= '0;
            mode_q     <= GATE_MODE_XOR;
            out_valid  <= 1'b0;
            out_parity <= 1'b0;
            out_beats  <= '0;
            out_trunc  <= 1'b0;
`ifdef GATE_PARITY_STREAM_CHECK_EN
            out_err    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc <= acc_next;
                        cnt <= cnt_next;
                        if (first) begin
                            mode_q <= in_mode;
                        end
                        if (frame_end) begin
                            out_valid  <= 1'b1;
                            out_parity <= par_next;
                            out_beats  <= cnt_next;
                            out_trunc  <= !in_last;
`ifdef GATE_PARITY_STREAM_CHECK_EN
                            out_err    <= (par_next != in_exp);
`endif
                            state      <= HOLD;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
